// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU: opcodes, FSM
// state encoding and default widths.
package alu_pkg;

  localparam int ALU_WIDTH_DEF = 16;
  localparam int ALU_CNT_W_DEF = 5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_MULU  = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIN  = 2'b11
  } alu_state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == ALU_MULU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One step per asserted step cycle; last is high while the final step is issued.
module alu_muldiv_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             div_mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  // For multiply, lo holds the multiplier and collects the product low half
  // as it shifts right; for divide, lo holds the dividend and collects quotient bits.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  end

  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load) begin
      div_d  = div_mode;
      hi_d   = '0;
      cnt_d  = '0;
      lo_d   = div_mode ? a : b;
      opnd_d = div_mode ? b : a;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lo   = lo_q;
  assign hi   = hi_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply/divide behind a start/busy/done handshake. Outputs hold between Done pulses.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF,
  parameter int CNT_W = ALU_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALU_1_IN,
  input  logic [WIDTH-1:0] ALU_2_IN,
  input  logic [3:0]       C_ALUOp,
  input  logic             C_ALUStart,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Hi,
  output logic             ALU_Zero,
  output logic             ALU_Neg,
  output logic             ALU_Ovf,
  output logic             ALU_DivZ,
  output logic             ALU_Busy,
  output logic             ALU_Done
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             divz_pend_q, divz_pend_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             divz_q, divz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] fin_out;
  logic [WIDTH-1:0] fin_hi;

  logic             it_load;
  logic             it_step;
  logic             it_last;
  logic [WIDTH-1:0] it_lo;
  logic [WIDTH-1:0] it_hi;

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (it_load),
    .div_mode (C_ALUOp == ALU_DIVU),
    .step     (it_step),
    .a        (ALU_1_IN),
    .b        (ALU_2_IN),
    .lo       (it_lo),
    .hi       (it_hi),
    .last     (it_last)
  );

  // Single-cycle results straight from the live operands; only used on the start edge.
  always_comb begin
    sum_w  = ALU_1_IN + ALU_2_IN;
    diff_w = ALU_1_IN - ALU_2_IN;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (C_ALUOp)
      ALU_ADD: begin
        sc_res = sum_w;
        sc_ovf = (ALU_1_IN[WIDTH-1] == ALU_2_IN[WIDTH-1]) &&
                 (sum_w[WIDTH-1] != ALU_1_IN[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff_w;
        sc_ovf = (ALU_1_IN[WIDTH-1] != ALU_2_IN[WIDTH-1]) &&
                 (diff_w[WIDTH-1] != ALU_1_IN[WIDTH-1]);
      end
      ALU_AND:   sc_res = ALU_1_IN & ALU_2_IN;
      ALU_OR:    sc_res = ALU_1_IN | ALU_2_IN;
      ALU_XOR:   sc_res = ALU_1_IN ^ ALU_2_IN;
      ALU_NOR:   sc_res = ~(ALU_1_IN | ALU_2_IN);
      ALU_SLL:   sc_res = ALU_1_IN << ALU_2_IN[3:0];
      ALU_SRL:   sc_res = ALU_1_IN >> ALU_2_IN[3:0];
      ALU_SRA:   sc_res = WIDTH'($signed(ALU_1_IN) >>> ALU_2_IN[3:0]);
      ALU_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(ALU_1_IN) < $signed(ALU_2_IN))};
      ALU_PASSB: sc_res = ALU_2_IN;
      default:   sc_res = '0;
    endcase
  end

  // Final write-back values for an iterative op.
  always_comb begin
    if (divz_pend_q) begin
      fin_out = '1;
      fin_hi  = a_q;
    end else begin
      fin_out = it_lo;
      fin_hi  = it_hi;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    divz_pend_d = divz_pend_q;
    out_d       = out_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    divz_d      = divz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    it_load     = 1'b0;
    it_step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (C_ALUStart) begin
          a_d         = ALU_1_IN;
          divz_pend_d = 1'b0;
          if (is_iterative(C_ALUOp)) begin
            busy_d = 1'b1;
            if (C_ALUOp == ALU_MULU) begin
              it_load = 1'b1;
              state_d = ST_MUL;
            end else if (ALU_2_IN == '0) begin
              divz_pend_d = 1'b1;
              state_d     = ST_FIN;
            end else begin
              it_load = 1'b1;
              state_d = ST_DIV;
            end
          end else begin
            out_d  = sc_res;
            hi_d   = '0;
            zero_d = (sc_res == '0);
            neg_d  = sc_res[WIDTH-1];
            ovf_d  = sc_ovf;
            divz_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        it_step = 1'b1;
        if (it_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        out_d   = fin_out;
        hi_d    = fin_hi;
        zero_d  = (fin_out == '0);
        neg_d   = fin_out[WIDTH-1];
        ovf_d   = 1'b0;
        divz_d  = divz_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      divz_pend_q <= 1'b0;
      out_q       <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      divz_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      divz_pend_q <= divz_pend_d;
      out_q       <= out_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      divz_q      <= divz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ALU_Out  = out_q;
  assign ALU_Hi   = hi_q;
  assign ALU_Zero = zero_q;
  assign ALU_Neg  = neg_q;
  assign ALU_Ovf  = ovf_q;
  assign ALU_DivZ = divz_q;
  assign ALU_Busy = busy_q;
  assign ALU_Done = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases, then random
// ops compared against an arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [3:0]  op_in = '0;
  logic        start = 1'b0;
  logic [15:0] alu_out, alu_hi;
  logic        alu_zero, alu_neg, alu_ovf, alu_divz, alu_busy, alu_done;

  int total = 0;
  int bad = 0;
  logic [15:0] last_out, last_hi;

  alu_multicycle dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALU_1_IN   (a_in),
    .ALU_2_IN   (b_in),
    .C_ALUOp    (op_in),
    .C_ALUStart (start),
    .ALU_Out    (alu_out),
    .ALU_Hi     (alu_hi),
    .ALU_Zero   (alu_zero),
    .ALU_Neg    (alu_neg),
    .ALU_Ovf    (alu_ovf),
    .ALU_DivZ   (alu_divz),
    .ALU_Busy   (alu_busy),
    .ALU_Done   (alu_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each opcode.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                                output logic [15:0] o, output logic [15:0] h,
                                output logic ovf, output logic divz, output int lat);
    int s;
    logic [31:0] p;
    logic [3:0] sh;
    sh = b[3:0];
    o = '0; h = '0; ovf = 1'b0; divz = 1'b0; lat = 1;
    case (op)
      ALU_ADD: begin
        s = int'($signed(a)) + int'($signed(b));
        o = 16'(s);
        ovf = (s > 32767) || (s < -32768);
      end
      ALU_SUB: begin
        s = int'($signed(a)) - int'($signed(b));
        o = 16'(s);
        ovf = (s > 32767) || (s < -32768);
      end
      ALU_AND:   o = a & b;
      ALU_OR:    o = a | b;
      ALU_XOR:   o = a ^ b;
      ALU_NOR:   o = ~(a | b);
      ALU_SLL:   o = a << sh;
      ALU_SRL:   o = a >> sh;
      ALU_SRA:   o = 16'($signed(a) >>> sh);
      ALU_SLT:   o = (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
      ALU_PASSB: o = b;
      ALU_MULU: begin
        p = 32'(a) * 32'(b);
        o = p[15:0];
        h = p[31:16];
        lat = 18;
      end
      ALU_DIVU: begin
        if (b == 16'd0) begin
          o = 16'hFFFF; h = a; divz = 1'b1; lat = 2;
        end else begin
          o = a / b; h = a % b; lat = 18;
        end
      end
      default: o = '0;
    endcase
  endfunction

  // Assumes the caller is 1 time unit after a rising edge; leaves it in the Done cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input int poke_cycle);
    logic [15:0] eo, eh;
    logic eovf, edivz;
    int elat, cyc;
    model(a, b, op, eo, eh, eovf, edivz, elat);
    a_in = a; b_in = b; op_in = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom); op_in = 4'($urandom);
    cyc = 1;
    while (alu_done !== 1'b1 && cyc < 40) begin
      check({tag, " busy_in_flight"}, 32'(alu_busy), 32'd1);
      if (cyc == poke_cycle) begin
        op_in = ALU_PASSB; b_in = 16'h5A5A; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(elat));
    check({tag, " busy_at_done"}, 32'(alu_busy), 32'd0);
    check({tag, " out"}, 32'(alu_out), 32'(eo));
    check({tag, " hi"}, 32'(alu_hi), 32'(eh));
    check({tag, " zero"}, 32'(alu_zero), 32'(eo == 16'd0));
    check({tag, " neg"}, 32'(alu_neg), 32'(eo[15]));
    check({tag, " ovf"}, 32'(alu_ovf), 32'(eovf));
    check({tag, " divz"}, 32'(alu_divz), 32'(edivz));
    last_out = eo;
    last_hi = eh;
    $display("op %-12s a=%04h b=%04h op=%0d -> out=%04h hi=%04h lat=%0d", tag, a, b, op, alu_out, alu_hi, cyc);
  endtask

  task automatic hold_check(input string tag);
    repeat (3) begin
      @(posedge clk); #1;
      check({tag, " done_low"}, 32'(alu_done), 32'd0);
    end
    check({tag, " out_held"}, 32'(alu_out), 32'(last_out));
    check({tag, " hi_held"}, 32'(alu_hi), 32'(last_hi));
  endtask

  initial begin
    int seen_done;
    logic [3:0] rop;
    logic [15:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check("reset out", 32'(alu_out), 32'd0);
    check("reset hi", 32'(alu_hi), 32'd0);
    check("reset flags", 32'({alu_zero, alu_neg, alu_ovf, alu_divz}), 32'd0);
    check("reset busy_done", 32'({alu_busy, alu_done}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Get nonzero outputs first so the mid-op reset has something to clear.
    run_op("pre_reset", 16'h8001, 16'h0001, ALU_OR, 0);
    a_in = 16'h0003; b_in = 16'h0005; op_in = ALU_MULU; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midreset out", 32'(alu_out), 32'd0);
    check("midreset flags", 32'({alu_zero, alu_neg, alu_ovf, alu_divz}), 32'd0);
    check("midreset busy_done", 32'({alu_busy, alu_done}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (alu_done === 1'b1) seen_done++;
    end
    check("midreset no_done", 32'(seen_done), 32'd0);
    check("midreset idle_busy", 32'(alu_busy), 32'd0);

    run_op("add_ovf", 16'h7FFF, 16'h0001, ALU_ADD, 0);
    run_op("sub_zero", 16'h1234, 16'h1234, ALU_SUB, 0);
    run_op("slt", 16'hFFFF, 16'h0001, ALU_SLT, 0);
    run_op("mulu_full", 16'hFFFF, 16'hFFFF, ALU_MULU, 4);
    run_op("divu", 16'h0064, 16'h0007, ALU_DIVU, 17);
    run_op("divz", 16'h0064, 16'h0000, ALU_DIVU, 0);
    run_op("sra", 16'h8000, 16'h0013, ALU_SRA, 0);
    run_op("srl_b2b", 16'h8000, 16'h0013, ALU_SRL, 0);
    hold_check("hold1");
    run_op("sub_ovf", 16'h8000, 16'h0001, ALU_SUB, 0);
    run_op("sll_hibits", 16'h0001, 16'hFFFF, ALU_SLL, 0);
    run_op("nor", 16'h0F0F, 16'h00FF, ALU_NOR, 0);
    run_op("passb", 16'h1111, 16'hBEEF, ALU_PASSB, 0);
    run_op("op_1111", 16'h1234, 16'h5678, 4'b1111, 0);
    run_op("mulu_small", 16'h0003, 16'h0005, ALU_MULU, 0);
    run_op("divu_big", 16'hFFFF, 16'h0001, ALU_DIVU, 0);
    hold_check("hold2");

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rop == ALU_DIVU && $urandom_range(0, 3) == 0) rb = 16'h0000;
      if (rop == ALU_DIVU && $urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
      run_op($sformatf("rand%0d", i), ra, rb, rop, 0);
      if ((i % 10) == 9) hold_check($sformatf("rhold%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
